// File: rtl/game_pkg.sv
// Shared game definitions: board geometry, cell encodings and the start-controller state type.
// The board RAM and the VGA renderer also use these.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    ACTIVE = 2'd2
  } start_state_t;

  localparam int BOARD_ROWS = 10;
  localparam int BOARD_COLS = 10;
  localparam int CELL_BITS  = 2;

  localparam logic [CELL_BITS-1:0] CELL_EMPTY = 2'd0;
  localparam logic [CELL_BITS-1:0] CELL_SNAKE = 2'd1;
  localparam logic [CELL_BITS-1:0] CELL_FOOD  = 2'd2;
  localparam logic [CELL_BITS-1:0] CELL_WALL  = 2'd3;

  // A one-cell board still needs a one-bit address port.
  function automatic int addr_width(input int cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a level that is already in the clk domain.
// RESET_VAL sets the history bit so that a level held through reset can be masked.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VAL;
    else       q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/game_start_ctrl.sv
// Round-launch controller: turns a START rising edge into a full board-RAM clear sweep.
// It then holds round_active until the game logic signals the end of the round.
module game_start_ctrl
  import game_pkg::*;
#(
  parameter int ROWS   = BOARD_ROWS,
  parameter int COLS   = BOARD_COLS,
  parameter int CELL_W = CELL_BITS,
  parameter logic [CELL_W-1:0] CLEAR_VAL = CELL_W'(CELL_EMPTY),
  localparam int AW = addr_width(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_in,
  input  logic              end_in,
  output logic              clr_we,
  output logic [AW-1:0]     clr_addr,
  output logic [CELL_W-1:0] clr_data,
  output logic              busy,
  output logic              round_active,
  output logic [7:0]        round_count
);

  localparam int CELLS = ROWS * COLS;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

  start_state_t  state;
  start_state_t  state_next;
  logic [AW-1:0] addr_cnt;
  logic [AW-1:0] addr_next;
  logic [7:0]    count_next;
  logic          launch;
  logic          sweep_done;

  // History bit resets high so a START level left on across reset is not seen as a new edge.
  rise_detect #(
    .RESET_VAL(1'b1)
  ) u_start_edge (
    .clk  (clk),
    .reset(reset),
    .d    (start_in),
    .rise (launch)
  );

  assign sweep_done = (state == CLEAR) && (addr_cnt == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_cnt    <= '0;
      round_count <= '0;
    end else begin
      state       <= state_next;
      addr_cnt    <= addr_next;
      round_count <= count_next;
    end
  end

  // The sweep is never interrupted; in ACTIVE a new launch outranks end_in.
  always_comb begin
    state_next = state;
    addr_next  = addr_cnt;
    count_next = round_count;
    unique case (state)
      IDLE: begin
        if (launch) begin
          state_next = CLEAR;
          addr_next  = '0;
        end
      end
      CLEAR: begin
        if (sweep_done) begin
          state_next = ACTIVE;
          addr_next  = '0;
          count_next = round_count + 8'd1;
        end else begin
          addr_next = addr_cnt + AW'(1);
        end
      end
      ACTIVE: begin
        if (launch) begin
          state_next = CLEAR;
          addr_next  = '0;
        end else if (end_in) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        addr_next  = '0;
      end
    endcase
  end

  assign clr_we       = (state == CLEAR);
  assign busy         = (state == CLEAR);
  assign round_active = (state == ACTIVE);
  assign clr_addr     = addr_cnt;
  assign clr_data     = CLEAR_VAL;

endmodule
